alu_result_serializer: RTL
==========================

Name: alu_result_serializer

Overview:
Downstream stage of the signed arithmetic unit. Captures each registered arithmetic result (2*WIDTH+1 bits, signed) when the unit's flag is high, and emits it as a byte-serial frame, MSB first, over a valid/ready byte interface toward the output link. A one-entry pending buffer absorbs a result that arrives while a frame is in flight. A sticky overflow flag records any result lost when both slots are occupied.

Parameters:
WIDTH, 16, operand width of the arithmetic unit; input result width is 2*WIDTH+1.
NBYTES (localparam), ceil((2*WIDTH+1)/8) = 5 at default, bytes per frame.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  result valid; driven by the arithmetic unit flag; one capture per high cycle.
in_data  input  2*WIDTH+1  signed result.
out_ready  input  1  downstream accepts out_data this cycle.
ovf_clr  input  1  synchronous clear of ovf.
out_valid  output  1  out_data valid.
out_data  output  8  current frame byte.
out_last  output  1  high with the final byte of a frame.
busy  output  1  high in SEND state or when pending buffer is full.
ovf  output  1  sticky: a result was dropped.
frame_cnt  output  8  count of completed frames, wraps 255 -> 0.

Behaviour:
- Reset (rst low, async): state IDLE, shifter and pending cleared, pending_full=0, byte_cnt=0. Outputs out_valid=0, out_data=0, out_last=0, busy=0, ovf=0, frame_cnt=0. Reset mid-frame abandons the frame and the pending entry. No partial completion.
- Frame format: in_data sign-extended to 8*NBYTES bits, sent as byte NBYTES-1 (MSB) down to byte 0.
- States: IDLE, SEND.
- IDLE + in_valid: load shifter from in_data. Go to SEND next cycle. out_valid rises the cycle after capture (1-cycle latency).
- SEND: out_valid=1. out_data = top byte of shifter. out_data and out_last stay stable until the handshake (out_valid & out_ready).
- Each handshake: shift left 8 and increment byte_cnt. out_last = (byte_cnt == NBYTES-1).
- Last-byte handshake increments frame_cnt.
  - If pending_full: load shifter from pending, clear pending_full, stay in SEND with no bubble.
  - Otherwise: go to IDLE.
- in_valid while SEND and pending empty: store in pending; pending_full=1.
- in_valid while SEND and pending full: drop the new result; ovf=1; pending unchanged.
- Simultaneous in_valid and last-byte handshake:
  - Pending full: pending moves to shifter and the new result goes to pending. No drop.
  - Pending empty: the new result loads the shifter directly. Stay in SEND, no bubble.
- ovf: set has priority over ovf_clr in the same cycle. Cleared only by ovf_clr or reset.
- out_ready low holds state indefinitely. No timeout.
- out_valid never drops mid-frame without a handshake.
- busy = (state==SEND) | pending_full.
- Upstream has no backpressure. Loss is reported only through ovf.

Test Plan:
- Single result, out_ready=1: in_data = 3*(-2) = 33'h1_FFFF_FFFA -> bytes FF,FF,FF,FF,FA on 5 consecutive cycles starting 1 cycle after in_valid. out_last only with FA. frame_cnt=1. Then IDLE, busy=0.
- Positive result with backpressure: in_data = 300 (0x12C); out_ready toggling 1,0,0,1,... -> bytes 00,00,00,01,2C. Each byte held while out_ready=0. No duplicates or skips.
- Back-to-back: in_valid with 5 then 7 on consecutive cycles, out_ready=1 -> frame ...05 immediately followed by frame ...07 with no idle cycle. frame_cnt=2. ovf=0.
- Overflow: out_ready=0, three in_valid pulses (1,2,3) -> ovf=1. Frames for 1 and 2 sent once out_ready=1; 3 lost. ovf_clr pulse -> ovf=0. ovf_clr coincident with a new drop -> ovf stays 1.
- Simultaneous load: pending holds 9, in_valid=1 with 4 on the last-byte handshake cycle -> frame 9 then frame 4, no drop, ovf=0.
- Reset mid-frame: rst low after 2 bytes of a frame with pending full -> all outputs 0 asynchronously. After release, IDLE, and the next in_valid starts a fresh frame at byte 0.

Source files
------------

// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - byte-serial framer for signed arithmetic results
// One frame in flight plus a one-entry pending buffer; overflow is sticky.
module alu_result_serializer #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2*WIDTH:0]   in_data,
  input  logic               out_ready,
  input  logic               ovf_clr,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic               out_last,
  output logic               busy,
  output logic               ovf,
  output logic [7:0]         frame_cnt
);

  localparam int IW     = 2*WIDTH + 1;
  localparam int NBYTES = (IW + 7) / 8;
  localparam int SW     = 8 * NBYTES;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [SW-1:0]   shifter;
  logic [IW-1:0]   pending;
  logic            pending_full;
  logic [CW-1:0]   byte_cnt;

  logic hs, last_hs, store, drop;

  function automatic logic [SW-1:0] sext(input logic [IW-1:0] d);
    return {{(SW-IW){d[IW-1]}}, d};
  endfunction

  assign out_valid = (state == SEND);
  assign out_data  = shifter[SW-1 -: 8];
  assign out_last  = (state == SEND) && (byte_cnt == LAST_IDX);
  assign busy      = (state == SEND) | pending_full;

  assign hs      = out_valid & out_ready;
  assign last_hs = hs & (byte_cnt == LAST_IDX);
  // On the last-byte handshake the pending slot is vacated this same cycle,
  // so a coincident result always finds room.
  assign store = in_valid & (state == SEND) & ~pending_full & ~last_hs;
  assign drop  = in_valid & (state == SEND) &  pending_full & ~last_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shifter      <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      byte_cnt     <= '0;
      ovf          <= 1'b0;
      frame_cnt    <= 8'd0;
    end else begin
      ovf <= drop | (ovf & ~ovf_clr);

      if (store) begin
        pending      <= in_data;
        pending_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            shifter  <= sext(in_data);
            byte_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (last_hs) begin
            frame_cnt <= frame_cnt + 8'd1;
            byte_cnt  <= '0;
            if (pending_full) begin
              shifter <= sext(pending);
              if (in_valid) pending <= in_data;
              else          pending_full <= 1'b0;
            end else if (in_valid) begin
              shifter <= sext(in_data);
            end else begin
              shifter <= {shifter[SW-9:0], 8'h00};
              state   <= IDLE;
            end
          end else if (hs) begin
            shifter  <= {shifter[SW-9:0], 8'h00};
            byte_cnt <= byte_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
